// File: rtl/iob_bus_pkg.sv
// Shared iob native bus helpers: request/response widths, field positions
// and the bus-merge FSM state encoding.
package iob_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Request layout, MSB first: {valid, addr, wdata, wstrb}
    function automatic int req_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int resp_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int req_valid_pos(input int aw, input int dw);
        return aw + dw + dw / 8;
    endfunction

    function automatic int req_addr_lsb(input int dw);
        return dw + dw / 8;
    endfunction

    function automatic int req_wdata_lsb(input int dw);
        return dw / 8;
    endfunction

    localparam int REQ_WSTRB_LSB   = 0;
    localparam int RESP_READY_POS  = 0;
    localparam int RESP_RDATA_LSB  = 1;

    localparam int REQ_W  = req_w(ADDR_W_DEF, DATA_W_DEF);
    localparam int RESP_W = resp_w(DATA_W_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } bus_state_t;

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-input round-robin arbiter. gnt is combinational from req; the
// last-served pointer moves whenever a grant is taken (advance).
module iob_rr_arb2 #(
    parameter bit D_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1: input 1 (dbus) was served last, so input 0 wins the next tie
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_d ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= ~D_FIRST;
        end else if (advance && (gnt != 2'b00)) begin
            last_d <= gnt[1];
        end
    end

endmodule

// File: rtl/iob_cpu_bus_merge.sv
// Merges the CPU instruction and data iob buses onto one slave port:
// arbitrate, register the winning request, route the response back.
module iob_cpu_bus_merge
    import iob_bus_pkg::*;
#(
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,
    parameter bit  D_FIRST = 1'b1,
    localparam int REQ_W   = req_w(ADDR_W, DATA_W),
    localparam int RESP_W  = resp_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  ibus_req,
    output logic [RESP_W-1:0] ibus_resp,
    input  logic [REQ_W-1:0]  dbus_req,
    output logic [RESP_W-1:0] dbus_resp,
    output logic [REQ_W-1:0]  s_req,
    input  logic [RESP_W-1:0] s_resp,
    output logic [1:0]        grant
);

    localparam int VALID_POS = req_valid_pos(ADDR_W, DATA_W);

    bus_state_t       state, state_n;
    logic             owner;
    logic             load;
    logic             s_ready;
    logic [1:0]       arb_req;
    logic [1:0]       gnt;
    logic [REQ_W-1:0] win_req;

    assign s_ready = s_resp[RESP_READY_POS];

    // Only arbitrate from IDLE, so nothing is dispatched in a response cycle
    assign arb_req = (state == IDLE) ? {dbus_req[VALID_POS], ibus_req[VALID_POS]} : 2'b00;
    assign win_req = gnt[1] ? dbus_req : ibus_req;

    iob_rr_arb2 #(
        .D_FIRST(D_FIRST)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .advance(load),
        .gnt    (gnt)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    load    = 1'b1;
                    state_n = gnt[1] ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (s_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s_req <= '0;
            owner <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                s_req <= win_req;
                owner <= gnt[1];
            end else if ((state != IDLE) && s_ready) begin
                s_req <= '0;
            end
        end
    end

    // Combinational return path; the non-owner always sees all zeros
    always_comb begin
        ibus_resp = '0;
        dbus_resp = '0;
        if (state == BUSY_I) begin
            ibus_resp = s_resp;
        end
        if (state == BUSY_D) begin
            dbus_resp = s_resp;
        end
    end

    assign grant = {(state != IDLE), owner};

endmodule
